// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared definitions for the two-port Wishbone arbiter:
//            state encoding, port indices, the default timeout, and the
//            round-robin pick function.
// Ports    : none (package)
// Options  : WB_ARB_TIMEOUT_EN (consumed by wb_port_arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_OWN_A = OWN_A,
    ST_OWN_B = OWN_B
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Round-robin decision: a tie goes to the port that did not own the bus last.
  function automatic arb_state_t arb_pick(input logic req_a,
                                          input logic req_b,
                                          input logic last_owner);
    arb_state_t pick;
    if (req_a && req_b) begin
      pick = (last_owner == PORT_B) ? ST_OWN_A : ST_OWN_B;
    end else if (req_a) begin
      pick = ST_OWN_A;
    end else if (req_b) begin
      pick = ST_OWN_B;
    end else begin
      pick = ST_IDLE;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_timeout
// Purpose  : Watchdog for the granted port. Counts cycles with strobe high and
//            no ack; when the count reaches TIMEOUT_CYCLES it raises a one-
//            cycle error pulse and restarts from zero.
// Ports    : clk       - clock
//            rst_n     - synchronous active-low reset
//            i_active  - owner holds cyc (counter cleared when low)
//            i_stb     - owner strobe
//            i_ack     - ack from the channel controller
//            i_clear   - grant is changing this cycle
//            o_err     - abort pulse for the owner
// Options  : instantiated only when WB_ARB_TIMEOUT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_clear,
  output logic o_err
);

  localparam logic [TMO_W-1:0] c_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] c_ONE   = TMO_W'(1);

  logic [TMO_W-1:0] r_cnt;
  logic             w_hit;

  // The hit is decoded from the registered count, so the abort is known at
  // the start of the cycle and can suppress the strobe without a comb loop.
  assign w_hit = i_active && (r_cnt == c_LIMIT);
  assign o_err = w_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || i_clear || i_ack || w_hit) begin
      r_cnt <= '0;
    end else if (i_stb) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Two-master Wishbone arbiter in front of the RAM channel
//            controller. Registered round-robin grant held for the whole
//            Wishbone cycle; combinational request/response muxing.
// Ports    : wb_clk_i, wb_rst_n_i      - clock, synchronous active-low reset
//            wbs_a_* / wbs_b_*         - upstream slave ports A and B
//            wbm_*                     - downstream master port
//            gnt_o                     - one-hot grant {B,A}, 00 when idle
// Options  : WB_ARB_TIMEOUT_EN - enables the stb-without-ack watchdog that
//            aborts a stalled beat with a one-cycle err to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMO_W          = 5
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,

  input  logic        wbs_a_cyc_i,
  input  logic        wbs_a_stb_i,
  input  logic        wbs_a_we_i,
  input  logic [3:0]  wbs_a_sel_i,
  input  logic [31:0] wbs_a_adr_i,
  input  logic [31:0] wbs_a_dat_i,
  output logic [31:0] wbs_a_dat_o,
  output logic        wbs_a_ack_o,
  output logic        wbs_a_err_o,

  input  logic        wbs_b_cyc_i,
  input  logic        wbs_b_stb_i,
  input  logic        wbs_b_we_i,
  input  logic [3:0]  wbs_b_sel_i,
  input  logic [31:0] wbs_b_adr_i,
  input  logic [31:0] wbs_b_dat_i,
  output logic [31:0] wbs_b_dat_o,
  output logic        wbs_b_ack_o,
  output logic        wbs_b_err_o,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,

  output logic [1:0]  gnt_o
);

  // Only the two-port, wide-enough-counter configuration is implemented.
  // This empty block marks an unsupported parameter set in elaboration.
  if ((NUM_PORTS != 2) || ((1 << TMO_W) <= TIMEOUT_CYCLES)) begin : g_cfg_unsupported
  end

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_last_owner;
  logic       w_last_owner_next;

  logic       w_req_a;
  logic       w_req_b;
  logic       w_owner_cyc;
  logic       w_owner_stb;
  logic       w_tmo_err;

  assign w_req_a = wbs_a_cyc_i & wbs_a_stb_i;
  assign w_req_b = wbs_b_cyc_i & wbs_b_stb_i;

  // --------------------------------------------------------------------------
  // Grant state register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state      <= ST_IDLE;
      r_last_owner <= PORT_B;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: the owner keeps the bus while it holds cyc. When it releases,
  // the same round-robin pick as IDLE runs in that cycle, with the releasing
  // port recorded as last owner, so a waiting port takes over without a gap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        w_state_next = arb_pick(w_req_a, w_req_b, r_last_owner);
      end
      ST_OWN_A: begin
        if (!wbs_a_cyc_i) begin
          w_last_owner_next = PORT_A;
          w_state_next      = arb_pick(w_req_a, w_req_b, PORT_A);
        end
      end
      ST_OWN_B: begin
        if (!wbs_b_cyc_i) begin
          w_last_owner_next = PORT_B;
          w_state_next      = arb_pick(w_req_a, w_req_b, PORT_B);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request/response muxing. Ack is passed straight through because the
  // controller's ack is a function of the live strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_sel_o   = 4'h0;
    wbm_adr_o   = 32'h0;
    wbm_dat_o   = 32'h0;
    wbs_a_ack_o = 1'b0;
    wbs_a_err_o = 1'b0;
    wbs_a_dat_o = 32'h0;
    wbs_b_ack_o = 1'b0;
    wbs_b_err_o = 1'b0;
    wbs_b_dat_o = 32'h0;
    w_owner_cyc = 1'b0;
    w_owner_stb = 1'b0;
    case (r_state)
      ST_OWN_A: begin
        w_owner_cyc = wbs_a_cyc_i;
        w_owner_stb = wbs_a_stb_i;
        wbm_cyc_o   = wbs_a_cyc_i;
        wbm_stb_o   = wbs_a_stb_i & ~w_tmo_err;
        wbm_we_o    = wbs_a_we_i;
        wbm_sel_o   = wbs_a_sel_i;
        wbm_adr_o   = wbs_a_adr_i;
        wbm_dat_o   = wbs_a_dat_i;
        wbs_a_ack_o = wbm_ack_i;
        wbs_a_dat_o = wbm_dat_i;
        wbs_a_err_o = w_tmo_err;
      end
      ST_OWN_B: begin
        w_owner_cyc = wbs_b_cyc_i;
        w_owner_stb = wbs_b_stb_i;
        wbm_cyc_o   = wbs_b_cyc_i;
        wbm_stb_o   = wbs_b_stb_i & ~w_tmo_err;
        wbm_we_o    = wbs_b_we_i;
        wbm_sel_o   = wbs_b_sel_i;
        wbm_adr_o   = wbs_b_adr_i;
        wbm_dat_o   = wbs_b_dat_i;
        wbs_b_ack_o = wbm_ack_i;
        wbs_b_dat_o = wbm_dat_i;
        wbs_b_err_o = w_tmo_err;
      end
      default: begin
      end
    endcase
  end

  assign gnt_o = {r_state == ST_OWN_B, r_state == ST_OWN_A};

  // --------------------------------------------------------------------------
  // Optional stalled-beat watchdog
  // --------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  logic w_grant_change;
  assign w_grant_change = (w_state_next != r_state);

  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .i_active (w_owner_cyc),
    .i_stb    (w_owner_stb),
    .i_ack    (wbm_ack_i),
    .i_clear  (w_grant_change),
    .o_err    (w_tmo_err)
  );
`else
  assign w_tmo_err = 1'b0;
  // Owner cyc is only consumed by the watchdog.
  logic w_unused_owner_cyc;
  assign w_unused_owner_cyc = w_owner_cyc;
`endif

endmodule
`default_nettype wire
